// File: rtl/prog_loader_ctrl.sv
// UART-driven instruction-memory loader: 16-bit little-endian word-count header, then LE 32-bit words.
// Optional inter-byte watchdog enabled by defining LOADER_TIMEOUT_EN.
module prog_loader_ctrl #(
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              upg_rst_o,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR} state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [23:0]       buf_q, buf_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [15:0]       new_len;
  logic              words_done;
`ifdef LOADER_TIMEOUT_EN
  logic [31:0]       tmo_q, tmo_d;
`endif

  assign new_len    = {rx_data_i, len_q[7:0]};
  // The counter is bumped with the strobe, so equality holds exactly while the last strobe is out.
  assign words_done = (32'(wcnt_q) == 32'(len_q));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    buf_d   = buf_q;
    wen_d   = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
`ifdef LOADER_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          state_d = LEN_LO;
          wcnt_d  = '0;
          bcnt_d  = '0;
        end
      end
      LEN_LO: begin
        if (rx_valid_i) begin
          len_d[7:0] = rx_data_i;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_valid_i) begin
          len_d[15:8] = rx_data_i;
          if (new_len == 16'd0)                         state_d = DONE;
          else if (32'(new_len) > (32'd1 << ADDR_W))    state_d = ERROR;
          else                                          state_d = DATA;
        end
      end
      DATA: begin
        if (wen_q && words_done) begin
          state_d = DONE;
        end else if (rx_valid_i && !words_done) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wen_d  = 1'b1;
            dat_d  = {rx_data_i, buf_q};
            adr_d  = wcnt_q[ADDR_W-1:0];
            wcnt_d = wcnt_q + 1'b1;
          end else begin
            buf_d[8*bcnt_q +: 8] = rx_data_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef LOADER_TIMEOUT_EN
    if (state_q == LEN_LO || state_q == LEN_HI || state_q == DATA) begin
      if (rx_valid_i) begin
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + 32'd1;
        if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) state_d = ERROR;
      end
    end
    if (state_d == LEN_LO && state_q != LEN_LO) tmo_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      buf_q   <= '0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      buf_q   <= buf_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
`ifdef LOADER_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // err_o is sticky by construction: ERROR is only left through start_i.
  assign upg_rst_o  = (state_q == IDLE) || (state_q == ERROR);
  assign upg_done_o = (state_q == DONE);
  assign err_o      = (state_q == ERROR);
  assign busy_o     = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Self-checking bench for prog_loader_ctrl: directed and random byte streams against a stream-level model.
module tb_prog_loader_ctrl;
  localparam int ADDR_W = 14;
`ifdef LOADER_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 10000000;
`endif

  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, rx_valid_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic upg_rst_o, upg_wen_o, upg_done_o, busy_o, err_o;
  logic [ADDR_W-1:0] upg_adr_o;
  logic [31:0] upg_dat_o;

  prog_loader_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .upg_rst_o(upg_rst_o), .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o), .upg_dat_o(upg_dat_o),
    .upg_done_o(upg_done_o), .busy_o(busy_o), .err_o(err_o));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, wen_cyc = -1, done_cyc = -1;
  logic wen_prev = 1'b0, done_prev = 1'b0;
  logic [7:0] stream[$];
  logic [ADDR_W+31:0] exp_q[$], got_q[$];
  bit exp_err;

  // Write monitor: captures every strobe and the cycle done rises.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (upg_wen_o) begin
      got_q.push_back({upg_adr_o, upg_dat_o});
      wen_cyc = cyc;
      n_chk++;
      if (wen_prev) begin
        n_fail++;
        $display("FAIL wen_pulse: strobe high %0d consecutive cycles, required 1", 2);
      end
    end
    if (upg_done_o && !done_prev) done_cyc = cyc;
    wen_prev  = upg_wen_o;
    done_prev = upg_done_o;
  end

  // Reference: interpret the byte stream directly.
  function automatic void build_model();
    int len;
    logic [31:0] w;
    exp_q.delete();
    len = int'(stream[0]) | (int'(stream[1]) << 8);
    exp_err = (len > (1 << ADDR_W));
    if (!exp_err)
      for (int i = 0; i < len; i++) begin
        w = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
        exp_q.push_back({i[ADDR_W-1:0], w});
      end
  endfunction

  task automatic pulse_start();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
  endtask

  task automatic send_bytes(int first, int last, int maxgap);
    for (int i = first; i <= last; i++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      rx_valid_i = 1'b1; rx_data_i = stream[i];
      @(negedge clk);
      rx_valid_i = 1'b0;
    end
  endtask

  task automatic run_load(string name, int maxgap);
    int n;
    got_q.delete(); wen_cyc = -1; done_cyc = -1;
    build_model();
    pulse_start();
    n_chk++;
    if (upg_rst_o !== 1'b0 || busy_o !== 1'b1 || err_o !== 1'b0 || upg_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_start: rst/busy/err/done=%b%b%b%b required 0100", name, upg_rst_o, busy_o, err_o, upg_done_o);
    end
    send_bytes(0, stream.size() - 1, maxgap);
    n = 0;
    while (!(upg_done_o || err_o) && n < 30) begin @(negedge clk); n++; end
    @(negedge clk);
    n_chk++;
    if (n >= 30) begin
      n_fail++;
      $display("FAIL %s_timeout: no done/err after 30 cycles", name);
    end
    n_chk++;
    if (err_o !== exp_err || upg_done_o !== !exp_err || upg_rst_o !== exp_err || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end: err/done/rst/busy=%b%b%b%b required %b%b%b0", name, err_o, upg_done_o,
               upg_rst_o, busy_o, exp_err, !exp_err, exp_err);
    end
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: %0d writes, required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_word%0d: adr/dat=%h required %h", name, i, got_q[i], exp_q[i]);
      end
    end
    if (exp_q.size() > 0) begin
      n_chk++;
      if (done_cyc != wen_cyc + 1) begin
        n_fail++;
        $display("FAIL %s_done_lat: done at cycle %0d, last strobe %0d, required strobe+1", name, done_cyc, wen_cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_chk++;
      if ({upg_rst_o, upg_done_o, upg_wen_o, err_o, busy_o} !== 5'b10000 || upg_adr_o !== '0 || upg_dat_o !== '0) begin
        n_fail++;
        $display("FAIL reset_idle%0d: rst/done/wen/err/busy=%b%b%b%b%b adr=%h dat=%h required 10000 0 0",
                 i, upg_rst_o, upg_done_o, upg_wen_o, err_o, busy_o, upg_adr_o, upg_dat_o);
      end
    end
  endtask

  task automatic test_basic();
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("basic", 3);
  endtask

  task automatic test_back_to_back();
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("b2b", 0);
  endtask

  task automatic test_zero_len();
    stream = '{8'h00, 8'h00};
    run_load("zero", 0);
    stream = '{8'h11, 8'h22, 8'h33, 8'h44};
    got_q.delete();
    send_bytes(0, 3, 0);
    repeat (3) @(negedge clk);
    n_chk++;
    if (got_q.size() != 0 || upg_done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL done_ignores_rx: writes=%0d done=%b required 0 1", got_q.size(), upg_done_o);
    end
  endtask

  task automatic test_too_long();
    stream = '{8'h01, 8'h40};
    run_load("len16385", 1);
    stream = '{8'hFF, 8'hFF};
    run_load("lenFFFF", 0);
    stream = '{8'h01, 8'h02, 8'h03, 8'h04};
    got_q.delete();
    send_bytes(0, 3, 0);
    n_chk++;
    if (got_q.size() != 0 || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_ignores_rx: writes=%0d err=%b required 0 1", got_q.size(), err_o);
    end
    pulse_start();
    n_chk++;
    if (err_o !== 1'b0 || upg_rst_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b rst=%b required 0 0", err_o, upg_rst_o);
    end
    stream = '{8'h01, 8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
    send_bytes(0, 5, 0);
    repeat (3) @(negedge clk);
    n_chk++;
    if (upg_done_o !== 1'b1 || got_q.size() != 1) begin
      n_fail++;
      $display("FAIL after_err_load: done=%b writes=%0d required 1 1", upg_done_o, got_q.size());
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int len = $urandom_range(1, 9);
      stream = '{len[7:0], 8'h00};
      for (int i = 0; i < 4 * len; i++) stream.push_back(8'($urandom));
      run_load($sformatf("rand%0d", t), (t % 2) ? 0 : 4);
    end
  endtask

  task automatic test_rst_midload();
    stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    pulse_start();
    send_bytes(0, 4, 0);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({upg_rst_o, upg_done_o, upg_wen_o, err_o, busy_o} !== 5'b10000 || upg_adr_o !== '0 || upg_dat_o !== '0) begin
      n_fail++;
      $display("FAIL rst_midload: rst/done/wen/err/busy=%b%b%b%b%b adr=%h dat=%h required 10000 0 0",
               upg_rst_o, upg_done_o, upg_wen_o, err_o, busy_o, upg_adr_o, upg_dat_o);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (upg_done_o !== 1'b0 || upg_rst_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: done=%b rst=%b busy=%b required 0 1 0", upg_done_o, upg_rst_o, busy_o);
    end
`ifdef LOADER_TIMEOUT_EN
    pulse_start();
    send_bytes(0, 2, 0);
    repeat (90) @(negedge clk);
    n_chk++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_early: err=%b at 90 idle cycles, required 0", err_o);
    end
    repeat (15) @(negedge clk);
    n_chk++;
    if (err_o !== 1'b1 || upg_rst_o !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_abort: err=%b rst=%b after 105 idle cycles, required 1 1", err_o, upg_rst_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_len();
    test_too_long();
    test_random();
    test_rst_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
